// File: rtl/uart_tx_engine_pkg.sv
// Shared UART transmit definitions: FSM state encoding, data-width limits and clamp helper.
// PARITY only exists when UART_TX_PARITY_EN is defined.
package UART_tx_pkg;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } tx_state_e;

  function automatic logic [3:0] clamp_data_bits(input logic [3:0] n);
    if (n < 4'(MIN_DATA_BITS)) return 4'(MIN_DATA_BITS);
    if (n > 4'(MAX_DATA_BITS)) return 4'(MAX_DATA_BITS);
    return n;
  endfunction

endpackage

// File: rtl/uart_tx_engine_baud_tick.sv
// Bit-period down-counter: load sets the count, tick fires while enabled at zero.
// Caller reloads on every tick, so one bit lasts div_i+1 enabled clocks.
module uart_baud_tick #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             enable_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = div_i;
    end else if (enable_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = enable_i && (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART frame serializer: start, 5..8 data bits LSB first, optional parity (UART_TX_PARITY_EN), 1-2 stops.
// tx goes low the cycle after accept; tx_ready only in IDLE or the last stop-bit clock (back-to-back).
module uart_tx_engine
  import UART_tx_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tx_valid,
  input  logic [7:0]       tx_data,
  output logic             tx_ready,
  input  logic [3:0]       data_bits,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             two_stop,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tx,
  output logic             busy,
  output logic             done
);

  tx_state_e        state_q, state_d;
  logic [7:0]       sh_q, sh_d;
  logic [3:0]       nb_q, nb_d;
  logic [3:0]       bit_q, bit_d;
  logic             two_q, two_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             arm_q;
  logic             tick, last_stop, ready_int, accept, tx_bit;
`ifdef UART_TX_PARITY_EN
  logic             par_q, par_d, pen_q, pen_d, odd_q, odd_d;
`else
  logic             unused_parity_cfg;
  assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

  assign last_stop = (state_q == STOP) && tick && (bit_q == (two_q ? 4'd1 : 4'd0));
  // arm_q keeps the first clock after reset release from accepting a frame.
  assign ready_int = ((state_q == IDLE) && arm_q) || last_stop;
  assign accept    = tx_valid && ready_int;
  assign tx_ready  = ready_int || !rst_n;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (accept || tick),
    .enable_i (state_q != IDLE),
    .div_i    (accept ? baud_div : div_q),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    nb_d    = nb_q;
    bit_d   = bit_q;
    two_d   = two_q;
    div_d   = div_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
    pen_d   = pen_q;
    odd_d   = odd_q;
`endif
    tx_bit  = 1'b1;
    case (state_q)
      IDLE: tx_bit = 1'b1;
      START: begin
        tx_bit = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_bit = sh_q[0];
        if (tick) begin
          sh_d = {1'b0, sh_q[7:1]};
`ifdef UART_TX_PARITY_EN
          par_d = par_q ^ sh_q[0];
`endif
          if (bit_q == nb_q - 4'd1) begin
            bit_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d = pen_q ? PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_bit = par_q ^ odd_q;
        if (tick) state_d = STOP;
      end
`endif
      STOP: begin
        tx_bit = 1'b1;
        if (tick) begin
          if (last_stop) state_d = IDLE;
          else           bit_d   = bit_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Capture overrides the STOP->IDLE return so a waiting frame starts with no idle bit.
    if (accept) begin
      state_d = START;
      sh_d    = tx_data;
      nb_d    = clamp_data_bits(data_bits);
      bit_d   = '0;
      two_d   = two_stop;
      div_d   = baud_div;
`ifdef UART_TX_PARITY_EN
      par_d   = 1'b0;
      pen_d   = parity_en;
      odd_d   = parity_odd;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sh_q    <= '0;
      nb_q    <= '0;
      bit_q   <= '0;
      two_q   <= 1'b0;
      div_q   <= '0;
      arm_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
      pen_q   <= 1'b0;
      odd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      nb_q    <= nb_d;
      bit_q   <= bit_d;
      two_q   <= two_d;
      div_q   <= div_d;
      arm_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
      pen_q   <= pen_d;
      odd_q   <= odd_d;
`endif
    end
  end

  assign tx   = tx_bit;
  assign busy = (state_q != IDLE);
  assign done = last_stop;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: wire patterns written as {stops, [parity], data, start}.
// Expected parity bits follow UART_TX_PARITY_EN as seen by this compile.
module tb_uart_tx_engine;

  localparam int DIV_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             tx_valid = 1'b0;
  logic [7:0]       tx_data = '0;
  logic [3:0]       data_bits = 4'd8;
  logic             parity_en = 1'b0;
  logic             parity_odd = 1'b0;
  logic             two_stop = 1'b0;
  logic [DIV_W-1:0] baud_div = '0;
  logic             tx_ready, tx, busy, done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_engine #(.DIV_W(DIV_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .data_bits  (data_bits),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
    .baud_div   (baud_div),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [7:0] d, input logic [3:0] nb, input bit pe, input bit po,
                       input bit ts, input int div);
    tx_data    = d;
    data_bits  = nb;
    parity_en  = pe;
    parity_odd = po;
    two_stop   = ts;
    baud_div   = DIV_W'(div);
    tx_valid   = 1'b1;
  endtask

  // Watches one frame from the first clock after acceptance; pat[i] is the i-th bit on the wire.
  task automatic run_frame(input string tag, input logic [15:0] pat, input int n, input int div,
                           input bit keep, input logic [7:0] next_d);
    int total, bad, busy_cnt, done_cnt, done_at;
    total = n * (div + 1);
    bad = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (tx !== pat[(k - 1) / (div + 1)]) bad++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 1) begin
        check({tag, "_rdy_start"}, 32'(tx_ready), 32'd0);
        if (keep) begin
          tx_data = next_d;
        end else begin
          tx_valid   = 1'b0;
          tx_data    = ~tx_data;
          data_bits  = 4'd6;
          parity_en  = ~parity_en;
          parity_odd = ~parity_odd;
          two_stop   = ~two_stop;
          baud_div   = baud_div + DIV_W'(5);
        end
      end
      if (k == total) check({tag, "_rdy_last"}, 32'(tx_ready), 32'd1);
    end
    check({tag, "_bits"}, bad, 32'd0);
    check({tag, "_busy_clks"}, busy_cnt, total);
    check({tag, "_done_cnt"}, done_cnt, 32'd1);
    check({tag, "_done_at"}, done_at, total);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    check({tag, "_idle_tx"}, 32'(tx), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1, 4 clocks per bit, done on clock 40
    drive(8'hA5, 4'd8, 1'b0, 1'b0, 1'b0, 3);
    check("a5_total_clks", 32'(10 * 4), 32'd40);
    run_frame("8n1_a5", 16'({1'b1, 8'hA5, 1'b0}), 10, 3, 1'b0, 8'h00);
    idle_check("8n1_a5");

    // 7E1: 0x41 has two ones in its low 7 bits, so even parity is 0
    drive(8'h41, 4'd7, 1'b1, 1'b0, 1'b0, 1);
`ifdef UART_TX_PARITY_EN
    run_frame("7e1_41", 16'({1'b1, 1'b0, 7'h41, 1'b0}), 10, 1, 1'b0, 8'h00);
`else
    run_frame("7e1_41", 16'({1'b1, 7'h41, 1'b0}), 9, 1, 1'b0, 8'h00);
`endif
    idle_check("7e1_41");

    // 8O2 on zero data: odd parity 1, two stop bits, 12 bit periods
    drive(8'h00, 4'd8, 1'b1, 1'b1, 1'b1, 2);
`ifdef UART_TX_PARITY_EN
    run_frame("8o2_00", 16'({2'b11, 1'b1, 8'h00, 1'b0}), 12, 2, 1'b0, 8'h00);
`else
    run_frame("8o2_00", 16'({2'b11, 8'h00, 1'b0}), 11, 2, 1'b0, 8'h00);
`endif
    idle_check("8o2_00");

    // Back-to-back at one clock per bit: second start directly after first stop
    drive(8'h55, 4'd8, 1'b0, 1'b0, 1'b0, 0);
    run_frame("b2b_55", 16'({1'b1, 8'h55, 1'b0}), 10, 0, 1'b1, 8'hAA);
    run_frame("b2b_aa", 16'({1'b1, 8'hAA, 1'b0}), 10, 0, 1'b0, 8'h00);
    idle_check("b2b_aa");

    // Reset in the middle of DATA (bit 0 of 0xF0 is low on the wire)
    drive(8'hF0, 4'd8, 1'b0, 1'b0, 1'b0, 3);
    repeat (8) begin
      @(negedge clk);
      tx_valid = 1'b0;
    end
    check("mid_data_tx_low", 32'(tx), 32'd0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx), 32'd1);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(tx_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    drive(8'h3C, 4'd8, 1'b0, 1'b0, 1'b0, 1);
    rst_n = 1'b1;
    #1;
    check("post_rst_ready0", 32'(tx_ready), 32'd0);
    @(negedge clk);
    check("post_rst_no_accept", 32'(busy), 32'd0);
    check("post_rst_ready1", 32'(tx_ready), 32'd1);
    run_frame("post_rst_3c", 16'({1'b1, 8'h3C, 1'b0}), 10, 1, 1'b0, 8'h00);
    idle_check("post_rst_3c");

    // data_bits clamp: 3 sends 5 bits, 12 sends 8 bits
    drive(8'h2A, 4'd3, 1'b0, 1'b0, 1'b0, 1);
    run_frame("clamp_lo", 16'({1'b1, 5'h0A, 1'b0}), 7, 1, 1'b0, 8'h00);
    idle_check("clamp_lo");
    drive(8'h96, 4'd12, 1'b0, 1'b0, 1'b0, 0);
    run_frame("clamp_hi", 16'({1'b1, 8'h96, 1'b0}), 10, 0, 1'b0, 8'h00);
    idle_check("clamp_hi");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_engine.md
UART_TX_ENGINE -- requirements
Module: uart_tx_engine

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of baud divisor.
REQ-002 SHALL have port clk  input  1  system clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port tx_valid  input  1  frame request.
REQ-005 SHALL have port tx_data  input  8  payload, LSB transmitted first.
REQ-006 SHALL have port tx_ready  output  1  engine accepts a frame this cycle.
REQ-007 SHALL have port data_bits  input  4  data bits per frame, legal 5..8.
REQ-008 SHALL have port parity_en  input  1  insert parity bit.
REQ-009 SHALL have port parity_odd  input  1  1 = odd, 0 = even parity.
REQ-010 SHALL have port two_stop  input  1  1 = two stop bits, 0 = one.
REQ-011 SHALL have port baud_div  input  DIV_W  clocks per bit minus one.
REQ-012 SHALL have port tx  output  1  serial line, idle high.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at frame end.

Function
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL accept a frame on tx_valid && tx_ready and capture tx_data, data_bits, parity_en, parity_odd, two_stop, baud_div in that cycle; later changes to these inputs SHALL have no effect on the frame in progress.
REQ-017 SHALL assert tx_ready in IDLE and in the final clock of the last stop bit; otherwise 0.
REQ-018 SHALL drive tx low starting the cycle after acceptance (START).
REQ-019 SHALL hold each bit for exactly baud_div+1 clocks using a down-counter reloaded at every bit boundary; baud_div=0 gives one clock per bit.
REQ-020 SHALL send data bits LSB first; DATA ends after data_bits bits.
REQ-021 SHALL clamp captured data_bits below 5 to 5 and above 8 to 8.
REQ-022 SHALL, when parity enabled, send XOR of the transmitted data bits (XNOR for odd) in PARITY; otherwise DATA proceeds directly to STOP.
REQ-023 SHALL drive tx high in STOP for one or two bit periods per captured two_stop.
REQ-024 SHALL pulse done for one cycle in the final clock of the last stop bit.
REQ-025 SHALL, if tx_valid is high in that final clock, accept the next frame and enter START with no idle bit; otherwise return to IDLE.
REQ-026 SHALL assert busy in every state except IDLE.
REQ-027 SHALL hold tx high in IDLE and ignore tx_valid while busy except per REQ-025.

Reset
REQ-028 SHALL on rst_n low, at any time including mid-frame, force IDLE, tx=1, tx_ready=1, busy=0, done=0, counters and shift register to 0.
REQ-029 SHALL not accept a frame in the first cycle after rst_n deasserts.

Configuration
REQ-030 SHALL compile PARITY state and parity logic only when UART_TX_PARITY_EN is defined.
REQ-031 SHALL, without UART_TX_PARITY_EN, ignore parity_en and parity_odd and never emit a parity bit.

Structure
REQ-032 SHALL place the tx_state enum and constants (MIN_DATA_BITS=5, MAX_DATA_BITS=8) in shared package UART_tx_pkg.
REQ-033 SHALL implement the bit-period counter as sub-module uart_baud_tick (load, enable, tick output).

Verification
REQ-034 SHALL cover: baud_div=3, 8N1, tx_data=8'hA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, done after 40 clocks.
REQ-035 SHALL cover: 7E1, tx_data=8'h41, parity enabled, even -> parity bit 0, bit 7 not sent.
REQ-036 SHALL cover: 8O2, tx_data=8'h00 -> parity bit 1, two stop bits, busy for 12 bit periods.
REQ-037 SHALL cover: tx_valid held high for frames 8'h55 and 8'hAA -> second start bit follows last stop bit with zero idle clocks.
REQ-038 SHALL cover: rst_n asserted mid-DATA -> tx=1, busy=0 immediately; next frame transmits correctly.
REQ-039 SHALL cover: data_bits=3 and data_bits=12 -> 5 and 8 data bits sent respectively.
